// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises one byte per frame (start, 8 data bits
// LSB first, optional parity, 1 or 2 stop bits), one bit per baud tick.
// The baud input is a free-running divided clock that is only sampled as
// data, so every bit boundary is a clk_i-synchronous event.
//
// Handshake: a byte is taken on the rising clk_i edge where tx_valid_i and
// tx_ready_o are both 1. tx_data_i is captured on that edge. tx_ready_o is
// 1 only when the engine is idle. Outside that edge, tx_valid_i and
// tx_data_i are don't-care.
module uart_tx_engine #(
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       baud_clk_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic [2:0] dbg_state
);

  // Anything other than exactly 2 stop bits falls back to 1.
  localparam logic PAR_EN    = (PARITY_EN != 0);
  localparam logic PAR_ODD   = (PARITY_ODD != 0);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t     state, state_n;
  logic       sync1, sync2, hist;
  logic       tick;
  logic [7:0] data_q, data_n;
  logic [2:0] bit_idx, bit_idx_n, bit_idx_inc;
  logic       stop_cnt, stop_cnt_n;
  logic       tx_q, tx_n;
  logic       done_q, done_n;

  // Baud synchroniser and rising-edge history. These flops reset high so
  // that a baud input already high at reset release does not look like an
  // edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= baud_clk_i;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign tick        = sync2 & ~hist;
  assign bit_idx_inc = bit_idx + 3'd1;

  // FSM state plus datapath registers. The line and the done pulse are
  // registered so that tx_o never glitches.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      data_q   <= 8'h00;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      data_q   <= data_n;
      bit_idx  <= bit_idx_n;
      stop_cnt <= stop_cnt_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
    end
  end

  // Next-state logic. The captured byte is never shifted; the bit index
  // selects the outgoing bit, so the byte stays intact until the next
  // accept.
  always_comb begin
    state_n    = state;
    data_n     = data_q;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    tx_n       = tx_q;
    done_n     = 1'b0;
    unique case (state)
      IDLE: begin
        // A tick on the accept edge is ignored, because IDLE does not
        // look at tick.
        tx_n = 1'b1;
        if (tx_valid_i) begin
          data_n    = tx_data_i;
          bit_idx_n = 3'd0;
          state_n   = ALIGN;
        end
      end
      ALIGN: begin
        if (tick) begin
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          bit_idx_n = 3'd0;
          tx_n      = data_q[0];
          state_n   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) begin
            if (PAR_EN) begin
              tx_n    = (^data_q) ^ PAR_ODD;
              state_n = PARITY;
            end else begin
              tx_n       = 1'b1;
              stop_cnt_n = 1'b0;
              state_n    = STOP;
            end
          end else begin
            bit_idx_n = bit_idx_inc;
            tx_n      = data_q[bit_idx_inc];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          tx_n       = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            stop_cnt_n = 1'b1;
          end
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  assign tx_ready_o = (state == IDLE);
  assign tx_busy_o  = ~tx_ready_o;
  assign tx_o       = tx_q;
  assign tx_done_o  = done_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: four instances cover the default
// framing, even parity, odd parity and two stop bits.
module tb_uart_tx_engine;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd3;

  logic       clk;
  logic       rst_n;
  logic       baud;
  logic       baud_run;
  logic [7:0] tx_data;
  logic [3:0] tx_valid;
  logic [3:0] tx, ready, busy, done;
  logic [2:0] st [4];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt [4] = '{0, 0, 0, 0};

  uart_tx_engine u_dflt (
    .clk_i(clk), .rst_n_i(rst_n), .baud_clk_i(baud), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid[0]), .tx_ready_o(ready[0]), .tx_o(tx[0]),
    .tx_busy_o(busy[0]), .tx_done_o(done[0]), .dbg_state(st[0]));

  uart_tx_engine #(.PARITY_EN(1), .PARITY_ODD(0)) u_peven (
    .clk_i(clk), .rst_n_i(rst_n), .baud_clk_i(baud), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid[1]), .tx_ready_o(ready[1]), .tx_o(tx[1]),
    .tx_busy_o(busy[1]), .tx_done_o(done[1]), .dbg_state(st[1]));

  uart_tx_engine #(.PARITY_EN(1), .PARITY_ODD(1)) u_podd (
    .clk_i(clk), .rst_n_i(rst_n), .baud_clk_i(baud), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid[2]), .tx_ready_o(ready[2]), .tx_o(tx[2]),
    .tx_busy_o(busy[2]), .tx_done_o(done[2]), .dbg_state(st[2]));

  uart_tx_engine #(.STOP_BITS(2)) u_stop2 (
    .clk_i(clk), .rst_n_i(rst_n), .baud_clk_i(baud), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid[3]), .tx_ready_o(ready[3]), .tx_o(tx[3]),
    .tx_busy_o(busy[3]), .tx_done_o(done[3]), .dbg_state(st[3]));

  // ---------------- clock / reset / baud ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divide-by-16 baud source; baud_run freezes it at its current level.
  initial begin
    baud = 1'b0;
    forever begin
      #80;
      if (baud_run) baud = ~baud;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    for (int i = 0; i < 4; i++)
      if (done[i]) done_cnt[i] <= done_cnt[i] + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: bit k of the result is the k-th bit on the line.
  function automatic logic [15:0] frame_model(input logic [7:0] d,
                                              input int pen, input int podd,
                                              input int stops);
    logic [15:0] f;
    int k;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = d[i];
    k = 9;
    if (pen != 0) begin
      f[9] = (^d) ^ (podd != 0);
      k = 10;
    end
    for (int i = 0; i < stops; i++) f[k + i] = 1'b1;
    return f;
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input int idx, input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_valid[idx] = 1'b1;
    @(negedge clk);
    tx_valid[idx] = 1'b0;
    check_eq("accept_state", st[idx], S_ALIGN);
  endtask

  // Waits for the start bit, samples every bit mid-period, then checks the
  // done pulse position, its width and the ready return.
  task automatic check_frame(input int idx, input int n,
                             output logic [15:0] got,
                             output int t_fall, output int t_done);
    logic found;
    got = '0;
    found = 1'b0;
    t_fall = cyc;
    t_done = cyc;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (tx[idx] == 1'b0) found = 1'b1;
    end
    check_eq("start_seen", found, 1'b1);
    if (!found) return;
    t_fall = cyc;
    repeat (8) @(negedge clk);
    got[0] = tx[idx];
    for (int k = 1; k < n; k++) begin
      repeat (16) @(negedge clk);
      got[k] = tx[idx];
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (done[idx]) found = 1'b1;
    end
    check_eq("done_seen", found, 1'b1);
    if (!found) return;
    t_done = cyc;
    check_eq("frame_len", t_done - t_fall, 16 * n);
    check_eq("ready_at_done", ready[idx], 1'b1);
    @(negedge clk);
    check_eq("done_width", done[idx], 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] got, got2;
  int tf, td, tf2, td2, snap;
  logic ready_hi;
  logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h3C};

  initial begin
    rst_n = 1'b1;
    baud_run = 1'b1;
    tx_valid = '0;
    tx_data = 8'h00;

    // Asynchronous reset asserted between clock edges.
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_tx", tx[0], 1'b1);
    check_eq("rst_ready", ready[0], 1'b1);
    check_eq("rst_busy", busy[0], 1'b0);
    check_eq("rst_done", done[0], 1'b0);
    check_eq("rst_state", st[0], S_IDLE);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    // Basic frame, 0xA5: line bits 0,1,0,1,0,0,1,0,1,1.
    send(0, 8'hA5);
    check_eq("busy_in_frame", busy[0], 1'b1);
    check_frame(0, 10, got, tf, td);
    check_eq("frame_a5", got, 16'h034A);
    check_eq("done_cnt_a5", done_cnt[0], 1);

    foreach (bytes[i]) begin
      send(0, bytes[i]);
      check_frame(0, 10, got, tf, td);
      check_eq("frame_dflt", got, frame_model(bytes[i], 0, 0, 1));
    end

    // Parity: 0xA5 has four ones, 0x01 has one.
    send(1, 8'hA5);
    check_frame(1, 11, got, tf, td);
    check_eq("even_par_a5", got[9], 1'b0);
    check_eq("frame_even_a5", got, frame_model(8'hA5, 1, 0, 1));
    send(1, 8'h01);
    check_frame(1, 11, got, tf, td);
    check_eq("even_par_01", got[9], 1'b1);
    send(2, 8'hA5);
    check_frame(2, 11, got, tf, td);
    check_eq("odd_par_a5", got[9], 1'b1);
    check_eq("frame_odd_a5", got, frame_model(8'hA5, 1, 1, 1));
    send(2, 8'h01);
    check_frame(2, 11, got, tf, td);
    check_eq("odd_par_01", got[9], 1'b0);

    // Back-to-back with two stop bits, valid held high.
    snap = done_cnt[3];
    @(negedge clk);
    tx_data = 8'h00;
    tx_valid[3] = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF;
    check_frame(3, 11, got, tf, td);
    tx_valid[3] = 1'b0;
    check_frame(3, 11, got2, tf2, td2);
    check_eq("b2b_frame0", got, frame_model(8'h00, 0, 0, 2));
    check_eq("b2b_frame1", got2, frame_model(8'hFF, 0, 0, 2));
    check_eq("b2b_gap", tf2 - td, 16);
    repeat (40) @(negedge clk);
    check_eq("b2b_done_cnt", done_cnt[3] - snap, 2);
    check_eq("b2b_idle", st[3], S_IDLE);

    // Inputs toggled during a frame must not disturb it.
    send(0, 8'h96);
    ready_hi = 1'b0;
    fork
      check_frame(0, 10, got, tf, td);
      begin
        for (int i = 0; i < 120; i++) begin
          @(negedge clk);
          if (ready[0]) ready_hi = 1'b1;
          tx_data = 8'($urandom_range(0, 255));
          tx_valid[0] = 1'($urandom_range(0, 1));
        end
        tx_valid[0] = 1'b0;
      end
    join
    check_eq("ignored_ready", ready_hi, 1'b0);
    check_eq("ignored_frame", got, frame_model(8'h96, 0, 0, 1));

    // Reset in the middle of data bit 3.
    send(0, 8'hC3);
    begin : wait_fall
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (tx[0] == 1'b0) disable wait_fall;
      end
    end
    repeat (72) @(negedge clk);
    check_eq("mid_state", st[0], S_DATA);
    snap = done_cnt[0];
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", tx[0], 1'b1);
    check_eq("mid_rst_ready", ready[0], 1'b1);
    repeat (30) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("mid_rst_no_done", done_cnt[0] - snap, 0);
    send(0, 8'h3A);
    check_frame(0, 10, got, tf, td);
    check_eq("after_rst_frame", got, frame_model(8'h3A, 0, 0, 1));

    // Reset release with baud frozen high: accept on the first edge, then
    // no tick until baud really rises again.
    @(posedge baud);
    baud_run = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    tx_data = 8'h5A;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    check_eq("first_edge_accept", st[0], S_ALIGN);
    repeat (40) @(negedge clk);
    check_eq("no_false_tick", st[0], S_ALIGN);
    check_eq("hold_tx", tx[0], 1'b1);
    baud_run = 1'b1;
    check_frame(0, 10, got, tf, td);
    check_eq("resume_frame", got, frame_model(8'h5A, 0, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
Parameters: one per line as name, default, meaning.
REQ-001 The block SHALL have parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-002 The block SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; it is ignored when PARITY_EN=0.
REQ-003 The block SHALL have parameter STOP_BITS, default 1: the number of stop bits, legal values 1 or 2.
Ports: one per line as name, direction, width, meaning.
REQ-004 clk_i, input, 1: the single system clock; all state SHALL be clocked on its rising edge.
REQ-005 rst_n_i, input, 1: reset, asynchronous and active-low.
REQ-006 baud_clk_i, input, 1: one divided-clock output of the clock-tree generator, used only as data and never as a clock.
REQ-007 tx_data_i, input, 8: byte to transmit.
REQ-008 tx_valid_i, input, 1: tx_data_i is valid.
REQ-009 tx_ready_o, output, 1: the engine can accept a byte.
REQ-010 tx_o, output, 1: serial line, idle high.
REQ-011 tx_busy_o, output, 1: a frame is pending or in progress.
REQ-012 tx_done_o, output, 1: one-cycle pulse when a frame completes.

Function
REQ-013 baud_clk_i SHALL pass through a 2-flop synchronizer and a rising-edge detector that produces tick, a one-clk_i-cycle pulse for each rising edge of baud_clk_i; tick SHALL lag that edge by 2-3 clk_i cycles.
REQ-014 The state machine SHALL have states IDLE, ALIGN, START, DATA, PARITY and STOP.
REQ-015 tx_ready_o SHALL be 1 only in IDLE, and tx_busy_o SHALL equal ~tx_ready_o.
REQ-016 A byte SHALL be accepted on the cycle where tx_valid_i && tx_ready_o; that cycle captures tx_data_i into a shift register and the state moves IDLE->ALIGN.
REQ-017 tx_valid_i and tx_data_i SHALL be ignored outside IDLE, and captured data SHALL not change until the next accept.
REQ-018 ALIGN->START SHALL occur on the first tick after accept, with tx_o driven 0 from the cycle after that tick.
REQ-019 Each later tick SHALL end the current bit period: START->DATA; DATA shifts LSB first for 8 bits via a 3-bit index 0..7; on index 7, DATA->PARITY if PARITY_EN, else DATA->STOP; PARITY->STOP.
REQ-020 The parity bit SHALL be the XOR of the 8 captured bits, inverted when PARITY_ODD=1.
REQ-021 In STOP, tx_o SHALL be 1 for STOP_BITS tick periods.
REQ-022 The tick that ends the last stop bit SHALL move the state STOP->IDLE and assert tx_done_o for exactly one clk_i cycle, the cycle after that tick.
REQ-023 tx_ready_o SHALL return to 1 in the same cycle that tx_done_o is asserted.
REQ-024 Frame length SHALL be (1 + 8 + PARITY_EN + STOP_BITS) tick periods, measured from the ALIGN tick.
REQ-025 For back-to-back transfers with tx_valid_i held high, the next byte SHALL be accepted in the tx_done_o cycle, with no extra idle beyond ALIGN.
REQ-026 tx_o SHALL be registered, glitch-free, and 1 in IDLE and ALIGN.
REQ-027 A tick coinciding with an accept SHALL not count; alignment SHALL wait for the next tick.
REQ-028 If baud_clk_i stops toggling, the block SHALL hold its current state and tx_o level indefinitely, with no timeout.
REQ-029 STOP_BITS values other than 1 or 2 SHALL be treated as 1.

Reset
REQ-030 While rst_n_i=0, and immediately on its assertion (asynchronously), the block SHALL drive state=IDLE, tx_o=1, tx_ready_o=1, tx_busy_o=0, tx_done_o=0, shift register=0 and bit index=0.
REQ-031 Both synchronizer flops and the edge-history flop SHALL reset to 1, so that no false tick occurs on reset release whatever the level of baud_clk_i.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no tx_done_o pulse, and the line SHALL return high at once.
REQ-033 After rst_n_i deasserts, the first accept SHALL be possible on the first clk_i edge.

Verification
All scenarios use a 10 ns clk_i, with baud_clk_i driven from a divide-by-16 output of the clock-tree generator (160 ns tick period).
REQ-034 Basic frame: defaults, 0xA5 with a one-cycle valid -> tx_o sequence per tick period 0,1,0,1,0,0,1,0,1,1; one tx_done_o pulse at 10 tick periods after the ALIGN tick.
REQ-035 Even parity: PARITY_EN=1, PARITY_ODD=0, byte 0xA5 -> parity bit 0, 11-tick frame; with PARITY_ODD=1 -> parity bit 1.
REQ-036 Back-to-back with two stop bits: STOP_BITS=2, valid held high with 0x00 then 0xFF -> second start bit begins on the first tick after the first tx_done_o; each frame is 11 ticks; exactly two done pulses.
REQ-037 Ignored inputs: toggle tx_data_i and tx_valid_i during a frame -> transmitted bits are unchanged and tx_ready_o stays 0 until done.
REQ-038 Mid-frame reset: rst_n_i pulled low during DATA bit 3 -> tx_o=1 and tx_ready_o=1 within the same cycle, no done pulse; a new frame after release is correct.
REQ-039 Reset release with baud_clk_i high: no tick and no state change until the next real rising edge of baud_clk_i.
